// File: rtl/ex_stage_pkg.sv
// Shared encodings for the MIPS execute stage: ALU opcodes, reset word, forwarding selects.
`default_nettype none
package ex_stage_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;

  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // EX/MEM is the younger producer, so it must win over MEM/WB.
  function automatic fwd_sel_e fwd_select(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit)      return FWD_EXMEM;
    else if (memwb_hit) return FWD_MEMWB;
    else                return FWD_REG;
  endfunction
endpackage
`default_nettype wire

// File: rtl/ex_stage_alu.sv
// Combinational ALU: wrap-around arithmetic, signed SLT, unused opcodes yield zero.
`default_nettype none
module ex_stage_alu
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, and the EX/MEM pipeline register.
`default_nettype none
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_write_in,
  input  logic              mem_read_in,
  input  logic              reg_write_in,
  input  logic              reg_dst_in,
  input  logic              mem_to_reg_in,
  input  logic              ALU_src_in,
  input  logic [2:0]        ALU_op_in,
  input  logic [WIDTH-1:0]  read_data1_in,
  input  logic [WIDTH-1:0]  read_data2_in,
  input  logic [15:0]       imm_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic [REG_AW-1:0] rt_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              mem_write_out,
  output logic              mem_read_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic [WIDTH-1:0]  alu_result_out,
  output logic [WIDTH-1:0]  store_data_out,
  output logic [REG_AW-1:0] dst_out,
  output logic              zero_out
);
  logic              exmem_valid;
  logic              memwb_valid;
  fwd_sel_e          sel_a;
  fwd_sel_e          sel_b;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  fwd_b;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  imm_ext;
  logic [WIDTH-1:0]  alu_res;
  logic [REG_AW-1:0] dst_next;

  // Register 0 is hardwired, so a write targeting it never forwards.
  assign exmem_valid = reg_write_out && (dst_out != '0);
  assign memwb_valid = wb_reg_write && (wb_dst != '0);

  assign sel_a = fwd_select(exmem_valid && (dst_out == rs_in), memwb_valid && (wb_dst == rs_in));
  assign sel_b = fwd_select(exmem_valid && (dst_out == rt_in), memwb_valid && (wb_dst == rt_in));

  always_comb begin
    op_a = read_data1_in;
    case (sel_a)
      FWD_EXMEM: op_a = alu_result_out;
      FWD_MEMWB: op_a = wb_data;
      default:   op_a = read_data1_in;
    endcase
  end

  always_comb begin
    fwd_b = read_data2_in;
    case (sel_b)
      FWD_EXMEM: fwd_b = alu_result_out;
      FWD_MEMWB: fwd_b = wb_data;
      default:   fwd_b = read_data2_in;
    endcase
  end

  assign imm_ext  = {{(WIDTH-16){imm_in[15]}}, imm_in};
  assign op_b     = ALU_src_in ? imm_ext : fwd_b;
  assign dst_next = reg_dst_in ? rd_in : rt_in;

  ex_stage_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (ALU_op_in),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res)
  );

  // A flush only kills the side-effecting controls; data fields still load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      alu_result_out <= WIDTH'(WORD_ZERO);
      store_data_out <= WIDTH'(WORD_ZERO);
      dst_out        <= '0;
      zero_out       <= 1'b0;
    end else if (!stall) begin
      mem_write_out  <= mem_write_in & ~flush;
      mem_read_out   <= mem_read_in & ~flush;
      reg_write_out  <= reg_write_in & ~flush;
      mem_to_reg_out <= mem_to_reg_in;
      alu_result_out <= alu_res;
      store_data_out <= fwd_b;
      dst_out        <= dst_next;
      zero_out       <= (alu_res == '0);
    end
  end
endmodule
`default_nettype wire
